// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module   : multicycle_control_fsm
// Function : Main control FSM of the multicycle RV32I datapath; drives
//            datapath enables/muxes, ALUOp and the ALU_CONTROL decode bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [2:0] ALUOp,
    output logic [3:0] instruction_bits,
    output logic       error,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_AUIPC    = 4'd12;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            C_TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] C_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [3:0]    w_cur;
    logic [CW-1:0] r_wait_cnt;
    logic          w_waiting;
    logic          w_timeout;
    logic          w_pc_write;
    logic          w_mem_write;
    logic          w_ir_write;
    logic          w_reg_write;

    // While in reset the outputs decode as FETCH, independent of the held state.
    assign w_cur = RST ? S_FETCH : r_state;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE)) && !mem_ready;
    // Limit is compared before the increment so the error lands on the Nth wait edge.
    assign w_timeout = C_TO_EN && w_waiting && (r_wait_cnt == C_LIMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0000011,
                    7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = S_EXECUTER;
                    7'b0010011: w_next = S_EXECUTEI;
                    7'b1100011: w_next = S_BRANCH;
                    7'b1101111: w_next = S_JAL;
                    7'b0110111: w_next = S_LUI;
                    7'b0010111: w_next = S_AUIPC;
                    default:    w_next = S_ERROR;
                endcase
            end
            S_MEMADR:   w_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_ERROR:    w_next = S_ERROR;
            default:    w_next = S_ERROR;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (C_TO_EN && w_waiting)
                r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        ALUOp       = 3'b010;
        case (w_cur)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                ALUOp     = 3'b000;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                ALUOp     = 3'b011;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                ALUOp      = 3'b001;
                w_pc_write = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                ALUOp     = 3'b100;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                ALUOp     = 3'b100;
            end
            default: ;
        endcase
    end

    assign pc_write         = w_pc_write  & ~RST;
    assign mem_write        = w_mem_write & ~RST;
    assign ir_write         = w_ir_write  & ~RST;
    assign reg_write        = w_reg_write & ~RST;
    assign error            = (w_cur == S_ERROR);
    assign state_o          = w_cur;
    assign instruction_bits = {funct7_5, funct3};

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Function : Directed bench for multicycle_control_fsm (no-timeout and
//            TIMEOUT_CYCLES=4 instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic       CLK;
    logic       RST;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, error;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] ALUOp;
    logic [3:0] instruction_bits, state_o;

    logic       to_pc_write, to_adr_src, to_mem_write, to_ir_write, to_reg_write, to_error;
    logic [1:0] to_result_src, to_alu_src_a, to_alu_src_b;
    logic [2:0] to_ALUOp;
    logic [3:0] to_instruction_bits, to_state_o;

    int n_total = 0;
    int n_bad   = 0;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(0)) u_dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .ALUOp(ALUOp), .instruction_bits(instruction_bits), .error(error),
        .state_o(state_o)
    );

    multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(to_pc_write), .adr_src(to_adr_src),
        .mem_write(to_mem_write), .ir_write(to_ir_write), .result_src(to_result_src),
        .alu_src_a(to_alu_src_a), .alu_src_b(to_alu_src_b), .reg_write(to_reg_write),
        .ALUOp(to_ALUOp), .instruction_bits(to_instruction_bits), .error(to_error),
        .state_o(to_state_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 2 time units later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        RST = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 2);
        chk("rst_aluop", 32'(ALUOp), 2);
        chk("rst_error", 32'(error), 0);
        RST = 1'b0;

        // SUB: 0,1,6,8,0
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        #1;
        chk("sub_s0", 32'(state_o), 0);
        chk("sub_ir_write", 32'(ir_write), 1);
        tick(); chk("sub_s1", 32'(state_o), 1);
        chk("sub_dec_a", 32'(alu_src_a), 1);
        tick(); chk("sub_s6", 32'(state_o), 6);
        chk("sub_aluop", 32'(ALUOp), 0);
        chk("sub_ibits", 32'(instruction_bits), 8);
        chk("sub_rw_exec", 32'(reg_write), 0);
        tick(); chk("sub_s8", 32'(state_o), 8);
        chk("sub_rw_wb", 32'(reg_write), 1);
        tick(); chk("sub_back", 32'(state_o), 0);

        // LW with three low-ready cycles in MEMREAD
        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        tick(); chk("lw_s1", 32'(state_o), 1);
        tick(); chk("lw_s2", 32'(state_o), 2);
        chk("lw_adr_a", 32'(alu_src_a), 2);
        mem_ready = 1'b0;
        tick(); chk("lw_s3a", 32'(state_o), 3);
        chk("lw_adr_src", 32'(adr_src), 1);
        chk("lw_rw_rd", 32'(reg_write), 0);
        tick(); chk("lw_s3b", 32'(state_o), 3);
        tick(); chk("lw_s3c", 32'(state_o), 3);
        tick(); chk("lw_s3d", 32'(state_o), 3);
        mem_ready = 1'b1;
        tick(); chk("lw_s4", 32'(state_o), 4);
        chk("lw_rw", 32'(reg_write), 1);
        chk("lw_rsrc", 32'(result_src), 1);
        tick(); chk("lw_back", 32'(state_o), 0);
        chk("lw_to_err", 32'(to_error), 0);

        // BEQ taken, BNE not taken then taken when zero drops
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        tick(); tick(); chk("beq_s9", 32'(state_o), 9);
        chk("beq_pcw", 32'(pc_write), 1);
        chk("beq_aluop", 32'(ALUOp), 1);
        funct3 = 3'b001;
        tick(); chk("beq_back", 32'(state_o), 0);
        tick(); tick(); chk("bne_s9", 32'(state_o), 9);
        chk("bne_pcw_z1", 32'(pc_write), 0);
        chk("bne_aluop", 32'(ALUOp), 1);
        zero = 1'b0;
        #1;
        chk("bne_pcw_z0", 32'(pc_write), 1);
        tick(); chk("bne_back", 32'(state_o), 0);

        // LUI, AUIPC
        opcode = 7'b0110111;
        tick(); tick(); chk("lui_s11", 32'(state_o), 11);
        chk("lui_aluop", 32'(ALUOp), 4);
        chk("lui_a", 32'(alu_src_a), 3);
        tick(); chk("lui_s8", 32'(state_o), 8);
        chk("lui_rw", 32'(reg_write), 1);
        opcode = 7'b0010111;
        tick(); tick(); tick(); chk("auipc_s12", 32'(state_o), 12);
        chk("auipc_aluop", 32'(ALUOp), 4);
        chk("auipc_a", 32'(alu_src_a), 1);
        tick(); chk("auipc_s8", 32'(state_o), 8);

        // SW aborted by reset in MEMWRITE
        opcode = 7'b0100011; funct3 = 3'b010;
        tick(); tick(); tick(); chk("sw_s2", 32'(state_o), 2);
        mem_ready = 1'b0;
        tick(); chk("sw_s5", 32'(state_o), 5);
        chk("sw_mw", 32'(mem_write), 1);
        tick(); chk("sw_mw_hold", 32'(mem_write), 1);
        RST = 1'b1;
        #1;
        chk("sw_mw_in_rst", 32'(mem_write), 0);
        tick();
        RST = 1'b0;
        #1;
        chk("sw_rst_state", 32'(state_o), 0);
        chk("sw_rst_mw", 32'(mem_write), 0);

        // Timeout in FETCH on the 4th wait edge
        rst_pulse();
        mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("to_wait3", 32'(to_state_o), 0);
        chk("to_wait3_err", 32'(to_error), 0);
        tick();
        chk("to_state", 32'(to_state_o), 15);
        chk("to_err", 32'(to_error), 1);
        chk("noto_state", 32'(state_o), 0);
        chk("noto_err", 32'(error), 0);

        // Ready arriving on the limit cycle wins
        rst_pulse();
        mem_ready = 1'b0;
        tick(); tick(); tick();
        mem_ready = 1'b1;
        #1;
        chk("lim_pre", 32'(to_state_o), 0);
        tick();
        chk("lim_state", 32'(to_state_o), 1);
        chk("lim_err", 32'(to_error), 0);

        // Illegal opcode: sticky error, cleared by reset
        rst_pulse();
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        tick(); chk("ill_s1", 32'(state_o), 1);
        tick(); chk("ill_err_state", 32'(state_o), 15);
        chk("ill_err", 32'(error), 1);
        chk("ill_irw", 32'(ir_write), 0);
        chk("ill_pcw", 32'(pc_write), 0);
        tick(); chk("ill_sticky", 32'(error), 1);
        rst_pulse();
        chk("ill_rst_state", 32'(state_o), 0);
        chk("ill_rst_err", 32'(error), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
